md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core, alongside the ALU.
- Executes mult, multu, div and divu over a fixed number of cycles and holds the HI/LO registers; also services mthi and mtlo.
- HI and LO feed the EX-stage 3-input result mux, which selects among ALU result, HI and LO for mfhi/mflo.
- Exports busy to the hazard unit, which stalls dependent md instructions.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu
DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse launching the operation in md_op
md_op  input  2  0=mult, 1=multu, 2=div, 3=divu; sampled only when start=1
A  input  32  rs operand (post-forwarding)
B  input  32  rt operand (post-forwarding)
mthi  input  1  write A into HI
mtlo  input  1  write A into LO
busy  output  1  registered; high while an operation is in flight
HI  output  32  HI register, registered
LO  output  32  LO register, registered

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset, including mid-operation: on the next edge, HI=0, LO=0, busy=0, counter=0, pending results cleared. An in-flight operation is abandoned and never commits.
- Launch: start=1 sampled at edge t0 with busy=0.
  - The result is computed from A, B and md_op at t0 and latched into internal pending_hi/pending_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from t0.
- Countdown: the counter decrements on each edge while busy=1. At edge t0+N:
  - busy returns to 0;
  - HI/LO take pending_hi/pending_lo.
- Timing consequences:
  - busy is high for exactly N cycles.
  - New HI/LO values are visible after edge t0+N, and not before.
  - HI/LO keep their old values throughout the busy window.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; HI=[63:32], LO=[31:0].
  - multu: the same as mult, unsigned.
  - div: signed; LO=quotient, truncated toward zero; HI=remainder, with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu): the operation runs its full DIV_CYCLES with busy=1. On completion HI/LO are left unchanged.
- mthi/mtlo with busy=0 and start=0: the addressed register takes A on the next edge, with zero latency. Both may be asserted in the same cycle.
- Ignored requests:
  - start while busy=1: ignored. The hazard unit guarantees this does not occur; the unit must remain robust if it does.
  - mthi/mtlo while busy=1: ignored.
- Simultaneous start and mthi/mtlo (busy=0): start wins; the move is dropped.
- Completion edge: at edge t0+N, a start arriving in the same cycle is ignored, because busy is still 1 at that edge. It is accepted on the following cycle.
- The unit does not combine start into busy. The hazard unit stalls on (start | busy) itself.

Test Plan:
- Reset then idle: assert reset for 2 cycles → HI=0, LO=0, busy=0; outputs stable with no start.
- mult signed: A=0xFFFFFFFE (-2), B=3, md_op=0, start for 1 cycle → busy=1 for exactly 5 cycles; HI/LO unchanged until then; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: A=0xFFFFFFFF, B=2, md_op=1 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div/divu:
  - div A=-7 (0xFFFFFFF9), B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero and ignored requests: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu B=0 → busy for 10 cycles, HI=0x11, LO=0x22 afterwards. Pulse mthi A=0x55 and a second start mid-busy → both ignored.
- Reset mid-op and priority:
  - Start mult 7*6, assert reset at cycle 3 → busy=0, HI=LO=0; no commit at cycle 5.
  - start together with mtlo A=0x99 → mtlo dropped; LO=product after 5 cycles.

Source files
------------

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Request/response bundle between the EX-stage control and the
//               multiply/divide unit: launch, operands, HI/LO moves, busy and
//               the architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline control side: issues operations and moves, reads HI/LO.
    modport master (
        output start, md_op, A, B, mthi, mtlo,
        input  busy, HI, LO
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, md_op, A, B, mthi, mtlo,
        output busy, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : MIPS multiply/divide unit. Computes mult/multu/div/divu at
//               launch, holds the result as pending, and commits it to HI/LO
//               after a fixed busy window. Also services mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    // Both cycle counts must be at least 1.
    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_OP_MULT  = 2'd0;
    localparam logic [1:0] c_OP_MULTU = 2'd1;
    localparam logic [1:0] c_OP_DIV   = 2'd2;
    localparam logic [1:0] c_OP_DIVU  = 2'd3;

    logic               r_busy;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_pending_hi;
    logic [31:0]        r_pending_lo;
    logic               r_pending_commit;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    // ------------------------------------------------------------------
    // Multiply: 64-bit products of sign- or zero-extended operands; the
    // low 64 bits of the extended product are the exact 32x32 result.
    // ------------------------------------------------------------------
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_a_zx;
    logic [63:0] w_b_zx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_a_sx   = {{32{md.A[31]}}, md.A};
    assign w_b_sx   = {{32{md.B[31]}}, md.B};
    assign w_a_zx   = {32'd0, md.A};
    assign w_b_zx   = {32'd0, md.B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;

    // ------------------------------------------------------------------
    // Divide: unsigned divide of magnitudes, then fix signs. Quotient is
    // negative when operand signs differ; remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1,
    // negated, wraps back to 0x80000000 with remainder 0.
    // The divisor is forced to 1 on divide-by-zero so the datapath never
    // sees a zero divisor; the result is discarded in that case anyway.
    // ------------------------------------------------------------------
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed_div = (md.md_op == c_OP_DIV);
    assign w_a_neg      = w_signed_div & md.A[31];
    assign w_b_neg      = w_signed_div & md.B[31];
    assign w_a_mag      = w_a_neg ? (~md.A + 32'd1) : md.A;
    assign w_b_mag      = w_b_neg ? (~md.B + 32'd1) : md.B;
    assign w_div_zero   = (md.B == 32'd0);
    assign w_divisor    = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_divisor;
    assign w_r_mag      = w_a_mag % w_divisor;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------
    // Result select and busy-window length for the requested operation.
    // ------------------------------------------------------------------
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_commit;
    logic [c_CNT_W-1:0] w_load;

    // Pick the result, commit flag and cycle count for md_op.
    always_comb begin
        w_res_hi     = w_prod_s[63:32];
        w_res_lo     = w_prod_s[31:0];
        w_res_commit = 1'b1;
        w_load       = c_MULT_LOAD;
        case (md.md_op)
            c_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_res_hi     = w_rem;
                w_res_lo     = w_quot;
                w_res_commit = ~w_div_zero;
                w_load       = c_DIV_LOAD;
            end
            default: begin
                w_res_commit = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control qualifiers. A start on the completion edge is ignored since
    // busy is still high there; moves only land when idle and not starting.
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_done;
    logic w_move_ok;

    assign w_accept  = md.start & ~r_busy;
    assign w_done    = r_busy & (r_count == c_CNT_ONE);
    assign w_move_ok = ~r_busy & ~md.start;

    // Launch latches the pending result; the counter runs down while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy           <= 1'b0;
            r_count          <= '0;
            r_pending_hi     <= 32'd0;
            r_pending_lo     <= 32'd0;
            r_pending_commit <= 1'b0;
        end else if (w_accept) begin
            r_busy           <= 1'b1;
            r_count          <= w_load;
            r_pending_hi     <= w_res_hi;
            r_pending_lo     <= w_res_lo;
            r_pending_commit <= w_res_commit;
        end else if (r_busy) begin
            r_count <= r_count - c_CNT_ONE;
            if (w_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // HI/LO update from operation completion or from an idle mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (r_pending_commit) begin
                r_hi <= r_pending_hi;
                r_lo <= r_pending_lo;
            end
        end else if (w_move_ok) begin
            if (md.mthi) begin
                r_hi <= md.A;
            end
            if (md.mtlo) begin
                r_lo <= md.A;
            end
        end
    end

    assign md.busy = r_busy;
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;

endmodule
`default_nettype wire
